ps2_move_decoder: RTL
=====================

Name: ps2_move_decoder

Overview:
- Producer end of the `move` interface that the game controller FSM consumes.
- Takes scancode bytes from the PS/2 receiver core and decodes make/break sequences for arrow keys and, optionally, WASD.
- Latches the latest requested direction until the controller's READ_KEY step acknowledges it.
- Presents a stable 3-bit `move` code for the following cycles: obstacle lookup and position update.

Parameters:
- TIMEOUT_CYCLES, 50000: idle cycles allowed mid-sequence (after E0/F0) before abandoning it and returning to IDLE. 1 ms at 50 MHz.
- TW, $clog2(TIMEOUT_CYCLES): timeout counter width.
- REPEAT, 1: when 1, an ack with nothing pending re-issues the still-held direction.
- ENABLE_WASD, 1: when 1, non-extended W/A/S/D codes also decode.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ps2_byte  in  8  received scancode byte
- ps2_byte_valid  in  1  one-cycle strobe; ps2_byte is valid this cycle
- key_ack  in  1  one-cycle consume strobe (controller en_key & s_key)
- move  out  3  registered direction: 0 NONE, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN
- move_pending  out  1  a make event is latched and not yet consumed
- held_dir  out  3  direction currently held down, NONE if released
- decode_state  out  2  current sequence-parser state, for debug

Behaviour:
- Reset (async, resetn=0): move=0, move_pending=0, held_dir=0, pending register=0, state=IDLE, timeout counter=0.
- Parser states: IDLE=0, EXT=1 (after E0), BRK=2 (after F0), EXT_BRK=3 (after E0 F0). Transitions occur only on ps2_byte_valid.
  - IDLE: E0 -> EXT; F0 -> BRK. Any other byte stays in IDLE; if ENABLE_WASD and the byte is 1C/23/1D/1B (A/D/W/S -> LEFT/RIGHT/UP/DOWN), it is a make event.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT. Arrow bytes 6B/74/75/72 (LEFT/RIGHT/UP/DOWN) -> make event, then IDLE. Any other byte -> IDLE, no event.
  - BRK: any byte -> IDLE; a WASD byte (when enabled) is a break event.
  - EXT_BRK: any byte -> IDLE; an arrow byte is a break event.
  - Other byte values (including E1 pause sequences) are ignored.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle without ps2_byte_valid.
  - On reaching TIMEOUT_CYCLES-1, the parser returns to IDLE and the counter clears.
  - The counter clears on every valid byte and whenever the parser is in IDLE.
- Make event for direction d:
  - pending <= d, move_pending <= 1, held_dir <= d. The latest make wins.
  - Typematic repeats simply re-latch.
- Break event for direction d:
  - If held_dir == d, then held_dir <= NONE; otherwise no change.
  - pending is untouched, so a tap shorter than one controller tick is still delivered.
- key_ack:
  - move <= pending if move_pending=1.
  - Otherwise move <= held_dir if REPEAT=1; otherwise move <= NONE.
  - move_pending <= 0.
  - move holds between acks.
- Latency:
  - Final byte of a make sequence strobed at edge N -> move_pending=1 after edge N.
  - key_ack at edge M -> new move visible after edge M.
- Simultaneous events:
  - Make and ack in the same cycle: move takes the pre-edge pending/held values; the new make then sets pending and move_pending=1.
  - Break and ack in the same cycle: move uses the pre-edge held_dir.
- resetn asserted mid-sequence discards all parser and latch state immediately.

Decomposition:
- Shared package:
  - direction codes NONE/LEFT/RIGHT/UP/DOWN (same values the controller already decodes);
  - scancode constants E0, F0, arrow and WASD codes;
  - parser state encoding.
- One natural sub-module: ps2_dir_lut, combinational. Maps (byte, extended flag, ENABLE_WASD) to {is_dir, dir[2:0]}. Shared by the make and break paths.

Test Plan:
- resetn pulse low mid-run -> move=0, move_pending=0, held_dir=0, decode_state=0 asynchronously, before the next clk edge.
- Bytes E0,74, then key_ack -> move_pending=1 after 74; after ack, move=2 and move_pending=0.
- Byte 1D, then ack -> move=3 with ENABLE_WASD=1. The same stimulus with ENABLE_WASD=0 -> move_pending stays 0 and move=0.
- Held key (REPEAT=1):
  - E0,6B; ack -> move=1.
  - Second ack with no bytes -> move=1.
  - E0,F0,6B; ack -> move=0.
  - Quick tap E0,75,E0,F0,75 before the ack -> ack gives move=3.
- Timeout: E0, idle TIMEOUT_CYCLES cycles, then 72 -> decode_state back to 0 before 72; no event; ack -> move=0.
- Collision: pending=LEFT; E0 sent earlier; byte 75 and key_ack in the same cycle -> move=1, move_pending=1, held_dir=3; next ack -> move=3.

Source files
------------

// File: rtl/ps2_move_decoder_pkg.sv
// Shared constants for the PS/2 move decoder: direction codes, scancodes,
// parser state encoding and the direction lookup payload.
package ps2_move_decoder_pkg;

  localparam int unsigned DIR_W  = 3;
  localparam int unsigned BYTE_W = 8;

  // Direction codes as already decoded by the game controller
  localparam logic [DIR_W-1:0] DIR_NONE  = 3'd0;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd1;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd2;
  localparam logic [DIR_W-1:0] DIR_UP    = 3'd3;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd4;

  localparam logic [BYTE_W-1:0] SC_EXT = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK = 8'hF0;

  localparam logic [BYTE_W-1:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [BYTE_W-1:0] SC_ARROW_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] SC_ARROW_DOWN  = 8'h72;

  localparam logic [BYTE_W-1:0] SC_KEY_A = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_KEY_D = 8'h23;
  localparam logic [BYTE_W-1:0] SC_KEY_W = 8'h1D;
  localparam logic [BYTE_W-1:0] SC_KEY_S = 8'h1B;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic             is_dir;
    logic [DIR_W-1:0] dir;
  } dir_lut_t;

  // States in which the next byte belongs to the E0-extended code page
  function automatic logic is_ext_state(input parse_state_e s);
    return (s == PS_EXT) || (s == PS_EXT_BRK);
  endfunction

endpackage

// File: rtl/ps2_dir_lut.sv
// Combinational scancode-to-direction map, shared by the make and break paths.
module ps2_dir_lut
  import ps2_move_decoder_pkg::*;
#(
  parameter int unsigned ENABLE_WASD = 1
) (
  input  logic [BYTE_W-1:0] ps2_byte,
  input  logic              ext,
  output dir_lut_t          lut
);

  always_comb begin
    lut = '0;
    if (ext) begin
      case (ps2_byte)
        SC_ARROW_LEFT:  lut = '{is_dir: 1'b1, dir: DIR_LEFT};
        SC_ARROW_RIGHT: lut = '{is_dir: 1'b1, dir: DIR_RIGHT};
        SC_ARROW_UP:    lut = '{is_dir: 1'b1, dir: DIR_UP};
        SC_ARROW_DOWN:  lut = '{is_dir: 1'b1, dir: DIR_DOWN};
        default:        lut = '0;
      endcase
    end else if (ENABLE_WASD != 0) begin
      case (ps2_byte)
        SC_KEY_A: lut = '{is_dir: 1'b1, dir: DIR_LEFT};
        SC_KEY_D: lut = '{is_dir: 1'b1, dir: DIR_RIGHT};
        SC_KEY_W: lut = '{is_dir: 1'b1, dir: DIR_UP};
        SC_KEY_S: lut = '{is_dir: 1'b1, dir: DIR_DOWN};
        default:  lut = '0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_move_decoder.sv
// Decodes PS/2 make/break sequences into a latched 3-bit move code that the
// game controller consumes with key_ack.
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TW             = $clog2(TIMEOUT_CYCLES),
  parameter int unsigned REPEAT         = 1,
  parameter int unsigned ENABLE_WASD    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [BYTE_W-1:0] ps2_byte,
  input  logic              ps2_byte_valid,
  input  logic              key_ack,
  output logic [DIR_W-1:0]  move,
  output logic              move_pending,
  output logic [DIR_W-1:0]  held_dir,
  output logic [1:0]        decode_state
);

  parse_state_e     state;
  logic [TW-1:0]    idle_cnt;
  logic [DIR_W-1:0] pending;
  logic             ext;
  dir_lut_t         lut;
  logic             make_evt;
  logic             break_evt;

  assign ext = is_ext_state(state);

  ps2_dir_lut #(
    .ENABLE_WASD(ENABLE_WASD)
  ) u_dir_lut (
    .ps2_byte(ps2_byte),
    .ext     (ext),
    .lut     (lut)
  );

  // A direction byte completes a make in IDLE/EXT and a break in BRK/EXT_BRK
  assign make_evt  = ps2_byte_valid && lut.is_dir &&
                     ((state == PS_IDLE) || (state == PS_EXT));
  assign break_evt = ps2_byte_valid && lut.is_dir &&
                     ((state == PS_BRK) || (state == PS_EXT_BRK));

  assign decode_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= PS_IDLE;
      idle_cnt     <= '0;
      pending      <= DIR_NONE;
      move         <= DIR_NONE;
      move_pending <= 1'b0;
      held_dir     <= DIR_NONE;
    end else begin
      // Sequence parser with mid-sequence idle timeout
      if (ps2_byte_valid) begin
        idle_cnt <= '0;
        case (state)
          PS_IDLE: begin
            if (ps2_byte == SC_EXT) begin
              state <= PS_EXT;
            end else if (ps2_byte == SC_BRK) begin
              state <= PS_BRK;
            end
          end
          PS_EXT: begin
            if (ps2_byte == SC_BRK) begin
              state <= PS_EXT_BRK;
            end else if (ps2_byte == SC_EXT) begin
              state <= PS_EXT;
            end else begin
              state <= PS_IDLE;
            end
          end
          default: state <= PS_IDLE;
        endcase
      end else if (state == PS_IDLE) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state    <= PS_IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      // Ack consumes pre-edge latch values; a same-cycle make re-arms after it
      if (key_ack) begin
        if (move_pending) begin
          move <= pending;
        end else if (REPEAT != 0) begin
          move <= held_dir;
        end else begin
          move <= DIR_NONE;
        end
        move_pending <= 1'b0;
      end

      if (make_evt) begin
        pending      <= lut.dir;
        move_pending <= 1'b1;
        held_dir     <= lut.dir;
      end else if (break_evt && (held_dir == lut.dir)) begin
        held_dir <= DIR_NONE;
      end
    end
  end

endmodule
